ahb_to_axi_bridge: RTL and testbench

- AHB-Lite subordinate to AXI manager bridge. Lets AHB-side controllers reach AXI subordinates through the AXI interconnect.
- Every AHB NONSEQ/SEQ transfer becomes exactly one single-beat AXI read or write.
- Holds the AHB data phase with HREADY low until the AXI response arrives, then returns read data or an ERROR.
- Single transaction outstanding at a time.

---
 rtl/ahb_to_axi_bridge_if.sv | 59 +++++
 rtl/ahb_to_axi_bridge.sv | 268 ++++++++++++++++++++++++++
 tb/tb_ahb_to_axi_bridge.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_to_axi_bridge_if.sv
// rtl/ahb_to_axi_bridge_if.sv - AHB-Lite and AXI4 bus interfaces used by the bridge
interface ahb_bus_if;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    modport satellite_to_mux (
        input  haddr, htrans, hwrite, hsize, hburst, hwdata,
        output hrdata, hready, hresp
    );
endinterface

interface axi_bus_if;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport controller_to_mux (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );
endinterface

// File: rtl/ahb_to_axi_bridge.sv
// rtl/ahb_to_axi_bridge.sv - AHB-Lite to single-beat AXI bridge; optional posted writes via AHB_AXI_POSTED_WRITE_EN
module ahb_to_axi_bridge #(
    parameter logic [3:0] AXI_ID            = 4'h0,
    parameter bit         AHB_ERR_ON_EXOKAY = 1'b0
) (
    input  logic                 clk,
    input  logic                 nrst,
    ahb_bus_if.satellite_to_mux  ahb,
    axi_bus_if.controller_to_mux axi
`ifdef AHB_AXI_POSTED_WRITE_EN
    ,
    output logic                 posted_err
`endif
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_DATA = 3'd1,
        WR_AXI  = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4,
        ERR1    = 3'd5,
        ERR2    = 3'd6,
        PW_WAIT = 3'd7
    } state_t;

    state_t      state_q,   state_d;
    logic [31:0] addr_q,    addr_d;
    logic [2:0]  size_q,    size_d;
    logic        write_q,   write_d;
    logic [31:0] wdata_q,   wdata_d;
    logic [3:0]  wstrb_q,   wstrb_d;
    logic [31:0] wb_addr_q, wb_addr_d;
    logic [2:0]  wb_size_q, wb_size_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q,  w_done_d;

    logic        wr_active;
    logic        aw_valid;
    logic        w_valid;
    logic        ar_valid;
    logic        r_ready;
    logic        accept;
    logic        hready_c;
    logic        hresp_c;
    logic [31:0] hrdata_c;

    logic        unused_hburst;
    assign unused_hburst = ^ahb.hburst;

    function automatic logic is_err(input logic [1:0] resp);
        return resp[1] || (AHB_ERR_ON_EXOKAY && (resp == 2'b01));
    endfunction

    function automatic logic [3:0] strb_for(input logic [2:0] sz, input logic [1:0] a);
        case (sz)
            3'd0:    return 4'b0001 << a;
            3'd1:    return 4'b0011 << {a[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

`ifdef AHB_AXI_POSTED_WRITE_EN
    logic pw_active_q,  pw_active_d;
    logic posted_err_q, posted_err_d;

    assign wr_active  = pw_active_q;
    assign posted_err = posted_err_q;

    // Background write tracker: armed when the write buffer fills, retired by B; B errors become sticky
    always_comb begin
        pw_active_d  = pw_active_q;
        posted_err_d = posted_err_q;
        if (state_q == WR_DATA) begin
            pw_active_d = 1'b1;
        end else if (pw_active_q && axi.bvalid) begin
            pw_active_d = 1'b0;
            if (is_err(axi.bresp)) begin
                posted_err_d = 1'b1;
            end
        end
    end
`else
    logic unused_write;
    assign unused_write = write_q;
    assign wr_active    = (state_q == WR_AXI);
`endif

    // AW/W/B engine: AW and W each handshake once per write; done flags clear when B retires the write
    always_comb begin
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        aw_valid  = wr_active && !aw_done_q;
        w_valid   = wr_active && !w_done_q;
        if (wr_active && axi.bvalid) begin
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
        end else begin
            if (aw_valid && axi.awready) begin
                aw_done_d = 1'b1;
            end
            if (w_valid && axi.wready) begin
                w_done_d = 1'b1;
            end
        end
    end

    // Main FSM: AHB data-phase control and accept-point handling
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        size_d    = size_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        wb_addr_d = wb_addr_q;
        wb_size_d = wb_size_q;
        hready_c  = 1'b0;
        hresp_c   = 1'b0;
        hrdata_c  = 32'd0;
        ar_valid  = 1'b0;
        r_ready   = 1'b0;
        accept    = 1'b0;

        case (state_q)
            IDLE: begin
                hready_c = 1'b1;
                accept   = 1'b1;
            end
            WR_DATA: begin
                wdata_d   = ahb.hwdata;
                wstrb_d   = strb_for(size_q, addr_q[1:0]);
                wb_addr_d = addr_q;
                wb_size_d = size_q;
`ifdef AHB_AXI_POSTED_WRITE_EN
                hready_c  = 1'b1;
                accept    = 1'b1;
`else
                state_d   = WR_AXI;
`endif
            end
`ifndef AHB_AXI_POSTED_WRITE_EN
            WR_AXI: begin
                if (axi.bvalid) begin
                    if (is_err(axi.bresp)) begin
                        state_d = ERR1;
                    end else begin
                        hready_c = 1'b1;
                        accept   = 1'b1;
                    end
                end
            end
`endif
            RD_ADDR: begin
                ar_valid = 1'b1;
                if (axi.arready) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                r_ready = 1'b1;
                if (axi.rvalid) begin
                    if (is_err(axi.rresp)) begin
                        state_d = ERR1;
                    end else begin
                        hready_c = 1'b1;
                        hrdata_c = axi.rdata;
                        accept   = 1'b1;
                    end
                end
            end
            ERR1: begin
                hresp_c = 1'b1;
                state_d = ERR2;
            end
            ERR2: begin
                hresp_c  = 1'b1;
                hready_c = 1'b1;
                accept   = 1'b1;
            end
`ifdef AHB_AXI_POSTED_WRITE_EN
            PW_WAIT: begin
                if (axi.bvalid) begin
                    state_d = write_q ? WR_DATA : RD_ADDR;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            if (ahb.htrans[1]) begin
                addr_d  = ahb.haddr;
                size_d  = ahb.hsize;
                write_d = ahb.hwrite;
                state_d = ahb.hwrite ? WR_DATA : RD_ADDR;
`ifdef AHB_AXI_POSTED_WRITE_EN
                if (pw_active_d) begin
                    state_d = PW_WAIT;
                end
`endif
            end else begin
                state_d = IDLE;
            end
        end
    end

    // State and datapath registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q      <= IDLE;
            addr_q       <= 32'd0;
            size_q       <= 3'd0;
            write_q      <= 1'b0;
            wdata_q      <= 32'd0;
            wstrb_q      <= 4'd0;
            wb_addr_q    <= 32'd0;
            wb_size_q    <= 3'd0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
`ifdef AHB_AXI_POSTED_WRITE_EN
            pw_active_q  <= 1'b0;
            posted_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            write_q      <= write_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            wb_addr_q    <= wb_addr_d;
            wb_size_q    <= wb_size_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
`ifdef AHB_AXI_POSTED_WRITE_EN
            pw_active_q  <= pw_active_d;
            posted_err_q <= posted_err_d;
`endif
        end
    end

    assign ahb.hready  = hready_c;
    assign ahb.hresp   = hresp_c;
    assign ahb.hrdata  = hrdata_c;

    assign axi.awid    = AXI_ID;
    assign axi.awaddr  = wb_addr_q;
    assign axi.awlen   = 8'd0;
    assign axi.awsize  = wb_size_q;
    assign axi.awburst = 2'b01;
    assign axi.awvalid = aw_valid;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wlast   = 1'b1;
    assign axi.wvalid  = w_valid;
    assign axi.bready  = wr_active;
    assign axi.arid    = AXI_ID;
    assign axi.araddr  = addr_q;
    assign axi.arlen   = 8'd0;
    assign axi.arsize  = size_q;
    assign axi.arburst = 2'b01;
    assign axi.arvalid = ar_valid;
    assign axi.rready  = r_ready;

endmodule

// File: tb/tb_ahb_to_axi_bridge.sv
// tb/tb_ahb_to_axi_bridge.sv - directed self-checking bench for ahb_to_axi_bridge
module tb_ahb_to_axi_bridge;
    logic clk;
    logic nrst;
    int   vectors;
    int   miscompares;
    int   aw_hs;
    int   w_hs;
`ifdef AHB_AXI_POSTED_WRITE_EN
    logic posted_err;
`endif

    ahb_bus_if ahb_i ();
    axi_bus_if axi_i ();

    ahb_to_axi_bridge #(.AXI_ID(4'h5), .AHB_ERR_ON_EXOKAY(1'b0)) dut (
        .clk  (clk),
        .nrst (nrst),
        .ahb  (ahb_i),
        .axi  (axi_i)
`ifdef AHB_AXI_POSTED_WRITE_EN
        ,
        .posted_err (posted_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic bus_idle();
        ahb_i.haddr = 32'd0; ahb_i.htrans = 2'b00; ahb_i.hwrite = 1'b0;
        ahb_i.hsize = 3'd0;  ahb_i.hburst = 3'd0;  ahb_i.hwdata = 32'd0;
        axi_i.awready = 1'b0; axi_i.wready = 1'b0; axi_i.bvalid = 1'b0; axi_i.bresp = 2'b00;
        axi_i.arready = 1'b0; axi_i.rvalid = 1'b0; axi_i.rdata = 32'd0; axi_i.rresp = 2'b00;
    endtask

    task automatic ahb_addr(input logic [31:0] a, input logic w, input logic [2:0] sz);
        ahb_i.haddr = a; ahb_i.htrans = 2'b10; ahb_i.hwrite = w; ahb_i.hsize = sz; ahb_i.hburst = 3'd0;
    endtask

    task automatic test_reset();
        nrst = 1'b0; bus_idle();
        ahb_i.htrans = 2'b10; axi_i.bvalid = 1'b1; axi_i.rvalid = 1'b1; axi_i.rdata = 32'h1234;
        tick(); tick(); settle();
        vectors++; if (ahb_i.hready !== 1'b1) begin miscompares++; $display("FAIL rst_hready: got %b want 1", ahb_i.hready); end
        vectors++; if (ahb_i.hresp !== 1'b0) begin miscompares++; $display("FAIL rst_hresp: got %b want 0", ahb_i.hresp); end
        vectors++; if (ahb_i.hrdata !== 32'd0) begin miscompares++; $display("FAIL rst_hrdata: got %h want 0", ahb_i.hrdata); end
        vectors++; if (axi_i.awvalid !== 1'b0) begin miscompares++; $display("FAIL rst_awvalid: got %b want 0", axi_i.awvalid); end
        vectors++; if (axi_i.wvalid !== 1'b0) begin miscompares++; $display("FAIL rst_wvalid: got %b want 0", axi_i.wvalid); end
        vectors++; if (axi_i.arvalid !== 1'b0) begin miscompares++; $display("FAIL rst_arvalid: got %b want 0", axi_i.arvalid); end
        vectors++; if (axi_i.bready !== 1'b0) begin miscompares++; $display("FAIL rst_bready: got %b want 0", axi_i.bready); end
        vectors++; if (axi_i.rready !== 1'b0) begin miscompares++; $display("FAIL rst_rready: got %b want 0", axi_i.rready); end
        vectors++; if (axi_i.awid !== 4'h5 || axi_i.arid !== 4'h5) begin miscompares++; $display("FAIL rst_ids: got %h/%h want 5/5", axi_i.awid, axi_i.arid); end
        vectors++; if (axi_i.awlen !== 8'd0 || axi_i.arlen !== 8'd0) begin miscompares++; $display("FAIL rst_len: got %h/%h want 0/0", axi_i.awlen, axi_i.arlen); end
        vectors++; if (axi_i.awburst !== 2'b01 || axi_i.arburst !== 2'b01) begin miscompares++; $display("FAIL rst_burst: got %b/%b want 01/01", axi_i.awburst, axi_i.arburst); end
        vectors++; if (axi_i.wlast !== 1'b1) begin miscompares++; $display("FAIL rst_wlast: got %b want 1", axi_i.wlast); end
        vectors++; if (axi_i.araddr !== 32'd0 || axi_i.wstrb !== 4'd0) begin miscompares++; $display("FAIL rst_regs: got araddr %h wstrb %b want 0/0", axi_i.araddr, axi_i.wstrb); end
        nrst = 1'b1; bus_idle();
        tick();
    endtask

    task automatic test_word_read();
        ahb_addr(32'h100, 1'b0, 3'd2); settle();
        vectors++; if (ahb_i.hready !== 1'b1) begin miscompares++; $display("FAIL rd_accept: got hready %b want 1", ahb_i.hready); end
        tick(); ahb_i.htrans = 2'b00; axi_i.arready = 1'b1; settle();
        vectors++; if (axi_i.arvalid !== 1'b1) begin miscompares++; $display("FAIL rd_arvalid: got %b want 1", axi_i.arvalid); end
        vectors++; if (axi_i.araddr !== 32'h100) begin miscompares++; $display("FAIL rd_araddr: got %h want 100", axi_i.araddr); end
        vectors++; if (axi_i.arsize !== 3'd2) begin miscompares++; $display("FAIL rd_arsize: got %0d want 2", axi_i.arsize); end
        vectors++; if (ahb_i.hready !== 1'b0) begin miscompares++; $display("FAIL rd_wait1: got hready %b want 0", ahb_i.hready); end
        tick(); axi_i.arready = 1'b0; axi_i.rvalid = 1'b1; axi_i.rdata = 32'hDEADBEEF; axi_i.rresp = 2'b00; settle();
        vectors++; if (axi_i.rready !== 1'b1) begin miscompares++; $display("FAIL rd_rready: got %b want 1", axi_i.rready); end
        vectors++; if (ahb_i.hready !== 1'b1 || ahb_i.hresp !== 1'b0) begin miscompares++; $display("FAIL rd_done: got hready %b hresp %b want 1/0", ahb_i.hready, ahb_i.hresp); end
        vectors++; if (ahb_i.hrdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rd_hrdata: got %h want deadbeef", ahb_i.hrdata); end
        tick(); axi_i.rvalid = 1'b0; settle();
        vectors++; if (ahb_i.hrdata !== 32'd0 || axi_i.arvalid !== 1'b0) begin miscompares++; $display("FAIL rd_after: got hrdata %h arvalid %b want 0/0", ahb_i.hrdata, axi_i.arvalid); end
    endtask

    task automatic test_read_error();
        ahb_addr(32'h104, 1'b0, 3'd2); settle();
        tick(); ahb_i.htrans = 2'b00; axi_i.arready = 1'b1; settle();
        tick(); axi_i.arready = 1'b0; axi_i.rvalid = 1'b1; axi_i.rdata = 32'h11111111; axi_i.rresp = 2'b10; settle();
        vectors++; if (ahb_i.hready !== 1'b0 || ahb_i.hrdata !== 32'd0) begin miscompares++; $display("FAIL rderr_resp: got hready %b hrdata %h want 0/0", ahb_i.hready, ahb_i.hrdata); end
        tick(); axi_i.rvalid = 1'b0; axi_i.rresp = 2'b00; settle();
        vectors++; if (ahb_i.hresp !== 1'b1 || ahb_i.hready !== 1'b0) begin miscompares++; $display("FAIL rderr_err1: got hresp %b hready %b want 1/0", ahb_i.hresp, ahb_i.hready); end
        vectors++; if (axi_i.rready !== 1'b0) begin miscompares++; $display("FAIL rderr_rready: got %b want 0", axi_i.rready); end
        tick(); settle();
        vectors++; if (ahb_i.hresp !== 1'b1 || ahb_i.hready !== 1'b1) begin miscompares++; $display("FAIL rderr_err2: got hresp %b hready %b want 1/1", ahb_i.hresp, ahb_i.hready); end
        tick(); settle();
        vectors++; if (ahb_i.hresp !== 1'b0 || ahb_i.hready !== 1'b1) begin miscompares++; $display("FAIL rderr_idle: got hresp %b hready %b want 0/1", ahb_i.hresp, ahb_i.hready); end
    endtask

    task automatic test_exokay_read();
        ahb_addr(32'h108, 1'b0, 3'd2); settle();
        tick(); ahb_i.htrans = 2'b00; axi_i.arready = 1'b1; settle();
        tick(); axi_i.arready = 1'b0; axi_i.rvalid = 1'b1; axi_i.rdata = 32'h0BADCAFE; axi_i.rresp = 2'b01; settle();
        vectors++; if (ahb_i.hready !== 1'b1 || ahb_i.hresp !== 1'b0) begin miscompares++; $display("FAIL exokay_resp: got hready %b hresp %b want 1/0", ahb_i.hready, ahb_i.hresp); end
        vectors++; if (ahb_i.hrdata !== 32'h0BADCAFE) begin miscompares++; $display("FAIL exokay_data: got %h want 0badcafe", ahb_i.hrdata); end
        tick(); axi_i.rvalid = 1'b0; axi_i.rresp = 2'b00;
    endtask

    task automatic test_reset_mid();
        ahb_addr(32'h10C, 1'b0, 3'd2); settle();
        tick(); ahb_i.htrans = 2'b00; settle();
        vectors++; if (axi_i.arvalid !== 1'b1) begin miscompares++; $display("FAIL midrst_pre: got arvalid %b want 1", axi_i.arvalid); end
        nrst = 1'b0;
        tick(); settle();
        vectors++; if (axi_i.arvalid !== 1'b0 || ahb_i.hready !== 1'b1) begin miscompares++; $display("FAIL midrst_post: got arvalid %b hready %b want 0/1", axi_i.arvalid, ahb_i.hready); end
        nrst = 1'b1;
        tick();
    endtask

    task automatic test_stray();
        ahb_i.htrans = 2'b01; ahb_i.haddr = 32'h500; axi_i.bvalid = 1'b1; axi_i.rvalid = 1'b1; axi_i.rdata = 32'hFFFF0000; settle();
        vectors++; if (axi_i.bready !== 1'b0 || axi_i.rready !== 1'b0) begin miscompares++; $display("FAIL stray_ready: got bready %b rready %b want 0/0", axi_i.bready, axi_i.rready); end
        vectors++; if (ahb_i.hready !== 1'b1 || ahb_i.hrdata !== 32'd0) begin miscompares++; $display("FAIL stray_ahb: got hready %b hrdata %h want 1/0", ahb_i.hready, ahb_i.hrdata); end
        tick(); settle();
        vectors++; if (axi_i.arvalid !== 1'b0 || axi_i.awvalid !== 1'b0) begin miscompares++; $display("FAIL busy_ignored: got arvalid %b awvalid %b want 0/0", axi_i.arvalid, axi_i.awvalid); end
        bus_idle();
        tick();
    endtask

`ifndef AHB_AXI_POSTED_WRITE_EN
    task automatic test_byte_write();
        ahb_addr(32'h203, 1'b1, 3'd0); settle();
        vectors++; if (ahb_i.hready !== 1'b1) begin miscompares++; $display("FAIL bw_accept: got hready %b want 1", ahb_i.hready); end
        tick(); ahb_i.htrans = 2'b00; ahb_i.hwdata = 32'hAB000000; settle();
        vectors++; if (ahb_i.hready !== 1'b0 || axi_i.awvalid !== 1'b0) begin miscompares++; $display("FAIL bw_wrdata: got hready %b awvalid %b want 0/0", ahb_i.hready, axi_i.awvalid); end
        tick(); axi_i.awready = 1'b1; axi_i.wready = 1'b1; settle();
        vectors++; if (axi_i.awvalid !== 1'b1 || axi_i.wvalid !== 1'b1) begin miscompares++; $display("FAIL bw_valids: got aw %b w %b want 1/1", axi_i.awvalid, axi_i.wvalid); end
        vectors++; if (axi_i.awaddr !== 32'h203 || axi_i.awsize !== 3'd0) begin miscompares++; $display("FAIL bw_aw: got %h size %0d want 203/0", axi_i.awaddr, axi_i.awsize); end
        vectors++; if (axi_i.wstrb !== 4'b1000) begin miscompares++; $display("FAIL bw_wstrb: got %b want 1000", axi_i.wstrb); end
        vectors++; if (axi_i.wdata !== 32'hAB000000) begin miscompares++; $display("FAIL bw_wdata: got %h want ab000000", axi_i.wdata); end
        vectors++; if (ahb_i.hready !== 1'b0 || axi_i.bready !== 1'b1) begin miscompares++; $display("FAIL bw_wait: got hready %b bready %b want 0/1", ahb_i.hready, axi_i.bready); end
        tick(); axi_i.awready = 1'b0; axi_i.wready = 1'b0; axi_i.bvalid = 1'b1; axi_i.bresp = 2'b00; settle();
        vectors++; if (axi_i.awvalid !== 1'b0 || axi_i.wvalid !== 1'b0) begin miscompares++; $display("FAIL bw_once: got aw %b w %b want 0/0", axi_i.awvalid, axi_i.wvalid); end
        vectors++; if (ahb_i.hready !== 1'b1 || ahb_i.hresp !== 1'b0) begin miscompares++; $display("FAIL bw_done: got hready %b hresp %b want 1/0", ahb_i.hready, ahb_i.hresp); end
        tick(); axi_i.bvalid = 1'b0; settle();
        vectors++; if (axi_i.bready !== 1'b0) begin miscompares++; $display("FAIL bw_idle_bready: got %b want 0", axi_i.bready); end
    endtask

    task automatic test_split_aw_w();
        logic exp_w;
        ahb_addr(32'h308, 1'b1, 3'd2); settle();
        tick(); ahb_i.htrans = 2'b00; ahb_i.hwdata = 32'h12345678; settle();
        aw_hs = 0; w_hs = 0;
        for (int k = 0; k < 4; k++) begin
            tick(); axi_i.awready = (k == 3); axi_i.wready = 1'b1; settle();
            exp_w = (k == 0);
            vectors++; if (axi_i.awvalid !== 1'b1) begin miscompares++; $display("FAIL split_awvalid[%0d]: got %b want 1", k, axi_i.awvalid); end
            vectors++; if (axi_i.wvalid !== exp_w) begin miscompares++; $display("FAIL split_wvalid[%0d]: got %b want %b", k, axi_i.wvalid, exp_w); end
            if (axi_i.awvalid === 1'b1 && axi_i.awready === 1'b1) aw_hs++;
            if (axi_i.wvalid === 1'b1 && axi_i.wready === 1'b1) w_hs++;
            if (k == 0) begin
                vectors++; if (axi_i.wstrb !== 4'b1111) begin miscompares++; $display("FAIL split_wstrb: got %b want 1111", axi_i.wstrb); end
            end
        end
        tick(); axi_i.awready = 1'b0; axi_i.wready = 1'b0; axi_i.bvalid = 1'b1; axi_i.bresp = 2'b00; settle();
        vectors++; if (axi_i.awvalid !== 1'b0 || axi_i.wvalid !== 1'b0) begin miscompares++; $display("FAIL split_b_valids: got aw %b w %b want 0/0", axi_i.awvalid, axi_i.wvalid); end
        vectors++; if (ahb_i.hready !== 1'b1) begin miscompares++; $display("FAIL split_done: got hready %b want 1", ahb_i.hready); end
        vectors++; if (aw_hs !== 1 || w_hs !== 1) begin miscompares++; $display("FAIL split_hs_count: got aw %0d w %0d want 1/1", aw_hs, w_hs); end
        tick(); axi_i.bvalid = 1'b0;
    endtask

    task automatic test_write_error();
        ahb_addr(32'h400, 1'b1, 3'd2); settle();
        tick(); ahb_i.htrans = 2'b00; ahb_i.hwdata = 32'h1; settle();
        tick(); axi_i.awready = 1'b1; axi_i.wready = 1'b1; settle();
        tick(); axi_i.awready = 1'b0; axi_i.wready = 1'b0; axi_i.bvalid = 1'b1; axi_i.bresp = 2'b10; settle();
        vectors++; if (ahb_i.hready !== 1'b0 || ahb_i.hresp !== 1'b0) begin miscompares++; $display("FAIL wrerr_b: got hready %b hresp %b want 0/0", ahb_i.hready, ahb_i.hresp); end
        tick(); axi_i.bvalid = 1'b0; axi_i.bresp = 2'b00; settle();
        vectors++; if (ahb_i.hresp !== 1'b1 || ahb_i.hready !== 1'b0) begin miscompares++; $display("FAIL wrerr_err1: got hresp %b hready %b want 1/0", ahb_i.hresp, ahb_i.hready); end
        vectors++; if (axi_i.bready !== 1'b0) begin miscompares++; $display("FAIL wrerr_bready: got %b want 0", axi_i.bready); end
        tick(); settle();
        vectors++; if (ahb_i.hresp !== 1'b1 || ahb_i.hready !== 1'b1) begin miscompares++; $display("FAIL wrerr_err2: got hresp %b hready %b want 1/1", ahb_i.hresp, ahb_i.hready); end
        tick(); settle();
        vectors++; if (ahb_i.hresp !== 1'b0 || ahb_i.hready !== 1'b1) begin miscompares++; $display("FAIL wrerr_idle: got hresp %b hready %b want 0/1", ahb_i.hresp, ahb_i.hready); end
    endtask

    task automatic test_back_to_back();
        ahb_addr(32'h82, 1'b1, 3'd1); settle();
        tick(); ahb_i.htrans = 2'b00; ahb_i.hwdata = 32'hBEEF0000; settle();
        tick(); axi_i.awready = 1'b1; axi_i.wready = 1'b1; settle();
        vectors++; if (axi_i.wstrb !== 4'b1100) begin miscompares++; $display("FAIL b2b_half_wstrb: got %b want 1100", axi_i.wstrb); end
        tick(); axi_i.awready = 1'b0; axi_i.wready = 1'b0; axi_i.bvalid = 1'b1; ahb_addr(32'h40, 1'b0, 3'd2); settle();
        vectors++; if (ahb_i.hready !== 1'b1) begin miscompares++; $display("FAIL b2b_wr_done: got hready %b want 1", ahb_i.hready); end
        tick(); axi_i.bvalid = 1'b0; ahb_i.htrans = 2'b00; axi_i.arready = 1'b1; settle();
        vectors++; if (axi_i.arvalid !== 1'b1 || axi_i.araddr !== 32'h40) begin miscompares++; $display("FAIL b2b_ar: got arvalid %b araddr %h want 1/40", axi_i.arvalid, axi_i.araddr); end
        vectors++; if (axi_i.awvalid !== 1'b0 || axi_i.bready !== 1'b0) begin miscompares++; $display("FAIL b2b_wr_quiet: got awvalid %b bready %b want 0/0", axi_i.awvalid, axi_i.bready); end
        tick(); axi_i.arready = 1'b0; axi_i.rvalid = 1'b1; axi_i.rdata = 32'hCAFEF00D; settle();
        vectors++; if (ahb_i.hready !== 1'b1 || ahb_i.hrdata !== 32'hCAFEF00D) begin miscompares++; $display("FAIL b2b_rd: got hready %b hrdata %h want 1/cafef00d", ahb_i.hready, ahb_i.hrdata); end
        tick(); axi_i.rvalid = 1'b0;
    endtask
`else
    task automatic test_posted_write();
        ahb_addr(32'h10, 1'b1, 3'd2); settle();
        tick(); ahb_i.hwdata = 32'h55AA55AA; ahb_addr(32'h20, 1'b0, 3'd2); settle();
        vectors++; if (ahb_i.hready !== 1'b1) begin miscompares++; $display("FAIL pw_one_cycle: got hready %b want 1", ahb_i.hready); end
        tick(); ahb_i.htrans = 2'b00; axi_i.awready = 1'b1; axi_i.wready = 1'b1; settle();
        vectors++; if (ahb_i.hready !== 1'b0 || axi_i.arvalid !== 1'b0) begin miscompares++; $display("FAIL pw_stall0: got hready %b arvalid %b want 0/0", ahb_i.hready, axi_i.arvalid); end
        vectors++; if (axi_i.awvalid !== 1'b1 || axi_i.awaddr !== 32'h10 || axi_i.wdata !== 32'h55AA55AA) begin miscompares++; $display("FAIL pw_aw_w: got awvalid %b awaddr %h wdata %h want 1/10/55aa55aa", axi_i.awvalid, axi_i.awaddr, axi_i.wdata); end
        for (int i = 0; i < 5; i++) begin
            tick(); axi_i.awready = 1'b0; axi_i.wready = 1'b0; settle();
            vectors++; if (ahb_i.hready !== 1'b0 || axi_i.arvalid !== 1'b0 || posted_err !== 1'b0) begin miscompares++; $display("FAIL pw_stall[%0d]: got hready %b arvalid %b posted_err %b want 0/0/0", i, ahb_i.hready, axi_i.arvalid, posted_err); end
        end
        tick(); axi_i.bvalid = 1'b1; axi_i.bresp = 2'b10; settle();
        vectors++; if (ahb_i.hready !== 1'b0 || ahb_i.hresp !== 1'b0 || axi_i.bready !== 1'b1) begin miscompares++; $display("FAIL pw_b: got hready %b hresp %b bready %b want 0/0/1", ahb_i.hready, ahb_i.hresp, axi_i.bready); end
        tick(); axi_i.bvalid = 1'b0; axi_i.bresp = 2'b00; axi_i.arready = 1'b1; settle();
        vectors++; if (axi_i.arvalid !== 1'b1 || axi_i.araddr !== 32'h20) begin miscompares++; $display("FAIL pw_rd_issue: got arvalid %b araddr %h want 1/20", axi_i.arvalid, axi_i.araddr); end
        vectors++; if (posted_err !== 1'b1 || ahb_i.hresp !== 1'b0) begin miscompares++; $display("FAIL pw_err_flag: got posted_err %b hresp %b want 1/0", posted_err, ahb_i.hresp); end
        tick(); axi_i.arready = 1'b0; axi_i.rvalid = 1'b1; axi_i.rdata = 32'h600DF00D; settle();
        vectors++; if (ahb_i.hready !== 1'b1 || ahb_i.hresp !== 1'b0 || ahb_i.hrdata !== 32'h600DF00D) begin miscompares++; $display("FAIL pw_rd_done: got hready %b hresp %b hrdata %h want 1/0/600df00d", ahb_i.hready, ahb_i.hresp, ahb_i.hrdata); end
        tick(); axi_i.rvalid = 1'b0;
    endtask
`endif

    initial begin
        vectors = 0;
        miscompares = 0;
        nrst = 1'b0;
        bus_idle();
        test_reset();
        test_word_read();
        test_read_error();
        test_exokay_read();
        test_reset_mid();
        test_stray();
`ifndef AHB_AXI_POSTED_WRITE_EN
        test_byte_write();
        test_split_aw_w();
        test_write_error();
        test_back_to_back();
`else
        test_posted_write();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
